// File: rtl/irs_block_unpacker_v3_pkg.sv
// irs_block_unpacker_v3_pkg: header field positions, FSM states, stream word type and next-channel encoder
package irs_block_unpacker_v3_pkg;
    localparam int HDR_STATION_HI = 15;
    localparam int HDR_STATION_LO = 10;
    localparam int HDR_STACK_HI   = 9;
    localparam int HDR_STACK_LO   = 8;
    localparam int HDR_CHSEL_HI   = 7;
    localparam int HDR_CHSEL_LO   = 0;
    localparam int SAMPLE_BITS    = 12;
    localparam logic [0:0] ST_HDR  = 1'b0;
    localparam logic [0:0] ST_DATA = 1'b1;
    typedef struct packed {
        logic [15:0] dat;
        logic        sof;
        logic        eof;
        logic        busy;
    } irs_word_t;
    function automatic logic [2:0] lsb_idx(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) if (m[i]) r = 3'(i);
        return r;
    endfunction
endpackage

// File: rtl/irs_skid_buffer_v3.sv
// irs_skid_buffer_v3: 2-entry valid/ready buffer carrying a word with its framing bits
module irs_skid_buffer_v3 import irs_block_unpacker_v3_pkg::*; (
    input  logic      clk_i,
    input  logic      rst_n_i,
    input  irs_word_t s_dat_i,
    input  logic      s_valid_i,
    output irs_word_t m_dat_o,
    output logic      m_valid_o,
    input  logic      m_ready_i,
    output logic [1:0] occ_o
);
    irs_word_t  r_d0, r_d1;
    logic [1:0] r_cnt;
    logic       w_pop;
    always_comb begin
        m_valid_o = r_cnt != 2'd0;
        m_dat_o   = r_d0;
        occ_o     = r_cnt;
        w_pop     = m_valid_o & m_ready_i;
    end
    // Upstream never pushes into a full buffer; the read-credit logic guarantees space.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_d0  <= '0;
            r_d1  <= '0;
            r_cnt <= 2'd0;
        end else begin
            r_cnt <= r_cnt + {1'b0, s_valid_i} - {1'b0, w_pop};
            if (w_pop || r_cnt == 2'd0) r_d0 <= (r_cnt == 2'd2) ? r_d1 : s_dat_i;
            if (s_valid_i) r_d1 <= s_dat_i;
        end
    end
endmodule

// File: rtl/irs_block_unpacker_v3.sv
// irs_block_unpacker_v3: drains IRS readout blocks from the FIFO, tags samples with channel, frames sof/eof
module irs_block_unpacker_v3 import irs_block_unpacker_v3_pkg::*; #(
    parameter logic [1:0] STACK_NUMBER   = 2'd0,
    parameter int         SAMPLES_PER_CH = 64
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [5:0]  station_i,
    input  logic [15:0] irs_dat_i,
    input  logic        irs_valid_i,
    input  logic        irs_empty_i,
    output logic        irs_rd_o,
    output logic [15:0] dat_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        sof_o,
    output logic        eof_o,
    output logic        busy_o,
    output logic        hdr_err_o,
    output logic        fmt_err_o,
    output logic [15:0] blk_count_o
);
    localparam logic [5:0] LAST_SMP = 6'(SAMPLES_PER_CH - 1);
    logic [0:0]  r_state;
    logic        r_pend, r_hdr_err, r_fmt_err, r_busy_hold;
    logic [7:0]  r_mask;
    logic [2:0]  r_ch;
    logic [5:0]  r_smp;
    logic [15:0] r_blk;
    logic        w_acc, w_stray, w_pop, w_end_ch, w_last, w_hdr_bad;
    logic [7:0]  w_hmask, w_rem;
    logic [1:0]  w_occ;
    irs_word_t   w_in, w_out;
    always_comb begin
        w_acc     = irs_valid_i & r_pend;
        w_stray   = irs_valid_i & ~r_pend;
        w_hmask   = irs_dat_i[HDR_CHSEL_HI:HDR_CHSEL_LO];
        w_hdr_bad = irs_dat_i[HDR_STATION_HI:HDR_STATION_LO] != station_i ||
                    irs_dat_i[HDR_STACK_HI:HDR_STACK_LO] != STACK_NUMBER;
        w_rem     = r_mask & ~(8'd1 << r_ch);
        w_end_ch  = r_smp == LAST_SMP;
        w_last    = w_end_ch && w_rem == 8'd0;
        w_in      = (r_state == ST_HDR) ? {irs_dat_i, 1'b1, ~|w_hmask, |w_hmask}
                                        : {1'b0, r_ch, irs_dat_i[SAMPLE_BITS-1:0], 1'b0, w_last, 1'b1};
        valid_o   = w_occ != 2'd0;
        w_pop     = valid_o & ready_i;
        dat_o     = w_out.dat;
        sof_o     = valid_o & w_out.sof;
        eof_o     = valid_o & w_out.eof;
        busy_o    = valid_o ? w_out.busy : r_busy_hold;
        // Credit counts the slot freed by this cycle's transfer so a held-high ready_i sustains one word per cycle.
        irs_rd_o  = rst_n_i & ~irs_empty_i & (({1'b0, w_occ} + {2'b0, r_pend} - {2'b0, w_pop}) < 3'd2);
        hdr_err_o = r_hdr_err;
        fmt_err_o = r_fmt_err;
        blk_count_o = r_blk;
    end
    irs_skid_buffer_v3 u_skid (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .s_dat_i   (w_in),
        .s_valid_i (w_acc),
        .m_dat_o   (w_out),
        .m_valid_o (),
        .m_ready_i (ready_i),
        .occ_o     (w_occ)
    );
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= ST_HDR;
            r_pend      <= 1'b0;
            r_hdr_err   <= 1'b0;
            r_fmt_err   <= 1'b0;
            r_busy_hold <= 1'b0;
            r_mask      <= 8'd0;
            r_ch        <= 3'd0;
            r_smp       <= 6'd0;
            r_blk       <= 16'd0;
        end else begin
            r_pend <= irs_rd_o;
            if (w_pop && w_out.eof) r_blk <= r_blk + 16'd1;
            if (w_pop) r_busy_hold <= w_out.busy & ~w_out.eof;
            if (w_stray || (w_acc && r_state == ST_DATA && |irs_dat_i[15:SAMPLE_BITS])) r_fmt_err <= 1'b1;
            if (w_acc && r_state == ST_HDR) begin
                if (w_hdr_bad) r_hdr_err <= 1'b1;
                r_mask  <= w_hmask;
                r_ch    <= lsb_idx(w_hmask);
                r_smp   <= 6'd0;
                r_state <= (w_hmask != 8'd0) ? ST_DATA : ST_HDR;
            end else if (w_acc) begin
                r_smp <= w_end_ch ? 6'd0 : r_smp + 6'd1;
                if (w_end_ch) begin
                    r_mask <= w_rem;
                    r_ch   <= lsb_idx(w_rem);
                    if (w_rem == 8'd0) r_state <= ST_HDR;
                end
            end
        end
    end
endmodule

// File: tb/tb_irs_block_unpacker_v3.sv
// tb_irs_block_unpacker_v3: directed blocks through a FIFO model, output words checked against a scoreboard
module tb_irs_block_unpacker_v3;
    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [5:0]  station_i = 6'h29;
    logic [15:0] irs_dat_i = 16'h0;
    logic        irs_valid_i = 1'b0;
    logic        irs_empty_i = 1'b1;
    logic        ready_i = 1'b0;
    logic        irs_rd_o, valid_o, sof_o, eof_o, busy_o, hdr_err_o, fmt_err_o;
    logic [15:0] dat_o, blk_count_o;
    always #5 clk_i = ~clk_i;
    irs_block_unpacker_v3 dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .station_i   (station_i),
        .irs_dat_i   (irs_dat_i),
        .irs_valid_i (irs_valid_i),
        .irs_empty_i (irs_empty_i),
        .irs_rd_o    (irs_rd_o),
        .dat_o       (dat_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .sof_o       (sof_o),
        .eof_o       (eof_o),
        .busy_o      (busy_o),
        .hdr_err_o   (hdr_err_o),
        .fmt_err_o   (fmt_err_o),
        .blk_count_o (blk_count_o)
    );
    logic [15:0] fifo_q[$];
    logic [17:0] exp_q[$];
    int n_chk = 0, n_pass = 0;
    int cyc = 0, xfers = 0, first_x = -1, last_x = -1, n_total = 0, busy_hi = 0;
    logic rd_q = 1'b0, rnd_rdy = 1'b0, gaps = 1'b0;
    logic [15:0] rd_dat = 16'h0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    // Inputs change on the falling edge; outputs and irs_rd_o are sampled 1 time unit later.
    task automatic step();
        @(negedge clk_i);
        cyc++;
        irs_valid_i = rd_q;
        irs_dat_i   = rd_q ? rd_dat : 16'h0;
        irs_empty_i = (fifo_q.size() == 0) || (gaps && cyc % 3 == 0);
        ready_i     = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (gaps) chk("rd_while_empty", {31'd0, irs_rd_o & irs_empty_i}, 0);
        rd_q = irs_rd_o;
        if (irs_rd_o && fifo_q.size() != 0) rd_dat = fifo_q.pop_front();
        if (busy_o) busy_hi++;
        if (valid_o && ready_i) begin
            xfers++;
            if (first_x < 0) first_x = cyc;
            last_x = cyc;
            if (exp_q.size() == 0) chk("extra_word", xfers, n_total);
            else chk("word", {14'd0, sof_o, eof_o, dat_o}, {14'd0, exp_q.pop_front()});
        end
    endtask
    task automatic load(input logic [15:0] hdr, input logic bad_first);
        logic [7:0]  m;
        logic [15:0] raw;
        int k, nw;
        m  = hdr[7:0];
        nw = 1 + 64 * $countones(m);
        k  = 0;
        fifo_q.push_back(hdr);
        exp_q.push_back({1'b1, m == 8'd0, hdr});
        for (int c = 0; c < 8; c++) if (m[c]) for (int s = 0; s < 64; s++) begin
            raw = 16'((k * 37 + 5) & 12'hFFF);
            if (bad_first && k == 0) raw = 16'h1ABC;
            fifo_q.push_back(raw);
            exp_q.push_back({1'b0, k == nw - 2, 1'b0, 3'(c), raw[11:0]});
            k++;
        end
        n_total = nw;
        xfers = 0;
        first_x = -1;
        last_x = -1;
    endtask
    task automatic run(input int budget);
        int b = 0;
        while (exp_q.size() != 0 && b < budget) begin
            step();
            b++;
        end
        repeat (4) step();
        chk("drain", exp_q.size(), 0);
    endtask
    initial begin
        repeat (3) step();
        chk("rst_flags", {25'd0, valid_o, sof_o, eof_o, busy_o, hdr_err_o, fmt_err_o, irs_rd_o}, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_blk", blk_count_o, 0);
        rst_n_i = 1'b1;
        load(16'hA4FF, 1'b0);
        run(800);
        chk("t1_throughput", last_x - first_x, 512);
        chk("t1_blk", blk_count_o, 1);
        chk("t1_errs", {hdr_err_o, fmt_err_o}, 0);
        chk("t1_busy_end", busy_o, 0);
        busy_hi = 0;
        load(16'hA400, 1'b0);
        run(50);
        chk("t2_busy_never", busy_hi, 0);
        chk("t2_blk", blk_count_o, 2);
        rnd_rdy = 1'b1;
        load(16'hA481, 1'b0);
        run(1500);
        rnd_rdy = 1'b0;
        chk("t3_blk", blk_count_o, 3);
        chk("t3_errs", {hdr_err_o, fmt_err_o}, 0);
        load(16'hA601, 1'b1);
        run(400);
        chk("t4_hdr_err", hdr_err_o, 1);
        chk("t4_fmt_err", fmt_err_o, 1);
        chk("t4_blk", blk_count_o, 4);
        load(16'hA401, 1'b0);
        for (int g = 0; g < 200 && xfers < 31; g++) step();
        chk("t5_reach", xfers, 31);
        rst_n_i = 1'b0;
        #1;
        chk("t5_rst_flags", {25'd0, valid_o, sof_o, eof_o, busy_o, hdr_err_o, fmt_err_o, irs_rd_o}, 0);
        chk("t5_rst_blk", blk_count_o, 0);
        fifo_q.delete();
        exp_q.delete();
        rd_q = 1'b0;
        repeat (2) step();
        rst_n_i = 1'b1;
        load(16'hA402, 1'b0);
        run(400);
        chk("t5_blk", blk_count_o, 1);
        chk("t5_errs", {hdr_err_o, fmt_err_o}, 0);
        gaps = 1'b1;
        load(16'hA403, 1'b0);
        run(1000);
        gaps = 1'b0;
        chk("t6_blk", blk_count_o, 2);
        chk("t6_errs", {hdr_err_o, fmt_err_o}, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
